mem_port_arbiter: RTL

//  Merges the two next-level miss/writeback ports (instruction-side, data-side) of the chip's
//  top-level caches onto one external memory port. Sits directly downstream of the I/D

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (I/D) to single memory port arbiter: one request in flight, IDLE/WAIT/RESP FSM.
// Optional macro ARB_ROUND_ROBIN_EN selects alternating tie-break instead of fixed D-over-I.
module mem_port_arbiter #(
  parameter int BW_ADDRESS = 32,
  parameter int BW_BLOCK   = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_I_valid,
  input  logic                  i_I_r0w1,
  input  logic [BW_ADDRESS-1:0] i_I_rwaddr,
  input  logic [BW_BLOCK-1:0]   i_I_wdata,
  output logic                  o_I_ready,
  output logic [BW_BLOCK-1:0]   o_I_rdata,
  input  logic                  i_D_valid,
  input  logic                  i_D_r0w1,
  input  logic [BW_ADDRESS-1:0] i_D_rwaddr,
  input  logic [BW_BLOCK-1:0]   i_D_wdata,
  output logic                  o_D_ready,
  output logic [BW_BLOCK-1:0]   o_D_rdata,
  output logic                  o_mem_valid,
  output logic                  o_mem_r0w1,
  output logic [BW_ADDRESS-1:0] o_mem_rwaddr,
  output logic [BW_BLOCK-1:0]   o_mem_wdata,
  input  logic                  i_mem_ready,
  input  logic [BW_BLOCK-1:0]   i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state, w_state_next;
  logic                  r_grant_d, w_grant_d_next;
  logic                  r_req_r0w1, w_req_r0w1_next;
  logic [BW_ADDRESS-1:0] r_req_addr, w_req_addr_next;
  logic [BW_BLOCK-1:0]   r_req_wdata, w_req_wdata_next;
  logic                  r_mem_valid, w_mem_valid_next;
  logic                  r_I_ready, w_I_ready_next;
  logic                  r_D_ready, w_D_ready_next;
  logic [BW_BLOCK-1:0]   r_I_rdata, w_I_rdata_next;
  logic [BW_BLOCK-1:0]   r_D_rdata, w_D_rdata_next;
  logic                  w_pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  // r_last_d = 0 means I was granted last, so the first tie after reset goes to D.
  logic r_last_d;

  assign w_pick_d = i_D_valid && (!i_I_valid || !r_last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b0;
    end else if (r_state == S_IDLE && (i_I_valid || i_D_valid)) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  assign w_pick_d = i_D_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_grant_d_next   = r_grant_d;
    w_req_r0w1_next  = r_req_r0w1;
    w_req_addr_next  = r_req_addr;
    w_req_wdata_next = r_req_wdata;
    w_mem_valid_next = 1'b0;
    w_I_ready_next   = 1'b0;
    w_D_ready_next   = 1'b0;
    w_I_rdata_next   = r_I_rdata;
    w_D_rdata_next   = r_D_rdata;
    case (r_state)
      S_IDLE: begin
        if (i_I_valid || i_D_valid) begin
          w_state_next     = S_WAIT;
          w_grant_d_next   = w_pick_d;
          w_req_r0w1_next  = w_pick_d ? i_D_r0w1   : i_I_r0w1;
          w_req_addr_next  = w_pick_d ? i_D_rwaddr : i_I_rwaddr;
          w_req_wdata_next = w_pick_d ? i_D_wdata  : i_I_wdata;
          w_mem_valid_next = 1'b1;
        end
      end
      S_WAIT: begin
        w_mem_valid_next = 1'b1;
        if (i_mem_ready) begin
          // Response goes straight into the winner's output register; valid drops with it.
          w_state_next     = S_RESP;
          w_mem_valid_next = 1'b0;
          if (r_grant_d) begin
            w_D_ready_next = 1'b1;
            w_D_rdata_next = i_mem_rdata;
          end else begin
            w_I_ready_next = 1'b1;
            w_I_rdata_next = i_mem_rdata;
          end
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_d   <= 1'b0;
      r_req_r0w1  <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_mem_valid <= 1'b0;
      r_I_ready   <= 1'b0;
      r_D_ready   <= 1'b0;
      r_I_rdata   <= '0;
      r_D_rdata   <= '0;
    end else begin
      r_grant_d   <= w_grant_d_next;
      r_req_r0w1  <= w_req_r0w1_next;
      r_req_addr  <= w_req_addr_next;
      r_req_wdata <= w_req_wdata_next;
      r_mem_valid <= w_mem_valid_next;
      r_I_ready   <= w_I_ready_next;
      r_D_ready   <= w_D_ready_next;
      r_I_rdata   <= w_I_rdata_next;
      r_D_rdata   <= w_D_rdata_next;
    end
  end

  assign o_mem_valid  = r_mem_valid;
  assign o_mem_r0w1   = r_req_r0w1;
  assign o_mem_rwaddr = r_req_addr;
  assign o_mem_wdata  = r_req_wdata;
  assign o_I_ready    = r_I_ready;
  assign o_I_rdata    = r_I_rdata;
  assign o_D_ready    = r_D_ready;
  assign o_D_rdata    = r_D_rdata;

endmodule
